// File: rtl/order_pkg.sv
// order_pkg: shared types and constants for the order egress path.
package order_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 3;

  localparam logic       SIDE_BUY = 1'b1;
  localparam logic [7:0] HDR_BUY  = 8'h42;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_TX
  } sched_state_e;

  typedef struct packed {
    logic              buy;
    logic [DATA_W-1:0] px;
    logic [DATA_W-1:0] qty;
  } order_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i
// with wrap. ptr_i must be below NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // First active request at or after the pointer wins.
  always_comb begin
    int unsigned cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/order_egress_sched.sv
// order_egress_sched: arbitrates strategy order requests onto the order
// encoder, one order in flight at a time, under a token-bucket rate limit.
// Optional risk check on quantity: define ORDER_SCHED_RISK_CHECK_EN.
module order_egress_sched
  import order_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned TOKENS_MAX    = 8,
  parameter int unsigned REFILL_PERIOD = 100,
  parameter int unsigned WAIT_TIMEOUT  = 64,
  parameter int unsigned MAX_QTY       = 10000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_buy,
  input  logic [DATA_W*NUM_REQ-1:0] req_px,
  input  logic [DATA_W*NUM_REQ-1:0] req_qty,
  output logic                      enc_in_valid,
  output logic                      enc_in_buy,
  output logic [DATA_W-1:0]         enc_in_px,
  output logic [DATA_W-1:0]         enc_in_qty,
  input  logic                      snp_tvalid,
  input  logic                      snp_tready,
  input  logic                      snp_tlast,
  output logic [IDX_W-1:0]          grant_id,
  output logic [3:0]                tokens,
  output logic                      tx_timeout,
  output logic                      reject
);

  localparam int unsigned RC_W = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
  localparam int unsigned WT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFILL_PERIOD - 1);
  localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(WAIT_TIMEOUT - 1);
  localparam logic [3:0]       TOK_FULL = 4'(TOKENS_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [3:0]         tokens_q, tokens_d;
  logic [RC_W-1:0]    refill_cnt_q, refill_cnt_d;
  logic [WT_W-1:0]    wait_cnt_q, wait_cnt_d;
  order_t             order_q, order_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  order_t             win;
  logic               consume, refill;
  logic [NUM_REQ-1:0] ready_c;
  logic               valid_c, timeout_c, reject_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Select the winning requester's order fields.
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        win.buy = req_buy[i];
        win.px  = req_px[i*DATA_W +: DATA_W];
        win.qty = req_qty[i*DATA_W +: DATA_W];
      end
    end
  end

  // FSM next state, handshakes and order latching.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    order_d    = order_q;
    wait_cnt_d = wait_cnt_q;
    ready_c    = '0;
    valid_c    = 1'b0;
    timeout_c  = 1'b0;
    reject_c   = 1'b0;
    consume    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        // Gated on rst so req_ready drops the instant reset asserts.
        if (!rst && arb_any && tokens_q != '0) begin
          ready_c  = arb_gnt;
          grant_d  = arb_idx;
          rr_ptr_d = (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
`ifdef ORDER_SCHED_RISK_CHECK_EN
          if (win.qty == '0 || win.qty > DATA_W'(MAX_QTY)) begin
            reject_c = 1'b1;
          end else begin
            order_d = win;
            state_d = ST_ISSUE;
          end
`else
          order_d = win;
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        valid_c    = 1'b1;
        consume    = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (snp_tvalid && snp_tready && snp_tlast) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WT_LAST) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Token bucket: periodic refill saturating at full, one token per issue.
  always_comb begin
    refill       = (refill_cnt_q == RC_LAST);
    refill_cnt_d = refill ? '0 : refill_cnt_q + 1'b1;
    tokens_d     = tokens_q;
    if (refill && !consume) begin
      if (tokens_q != TOK_FULL) tokens_d = tokens_q + 1'b1;
    end else if (!refill && consume) begin
      tokens_d = tokens_q - 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath, pointer and bucket registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      tokens_q     <= TOK_FULL;
      refill_cnt_q <= '0;
      wait_cnt_q   <= '0;
      order_q      <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      tokens_q     <= tokens_d;
      refill_cnt_q <= refill_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      order_q      <= order_d;
    end
  end

`ifndef ORDER_SCHED_RISK_CHECK_EN
  logic unused_max_qty;
  assign unused_max_qty = ^MAX_QTY;
`endif

  assign req_ready    = ready_c;
  assign enc_in_valid = valid_c;
  assign enc_in_buy   = order_q.buy;
  assign enc_in_px    = order_q.px;
  assign enc_in_qty   = order_q.qty;
  assign grant_id     = grant_q;
  assign tokens       = tokens_q;
  assign tx_timeout   = timeout_c;
  assign reject       = reject_c;

endmodule

// File: doc/order_egress_sched.md
Name: order_egress_sched

Overview:
- Arbitrates order requests from NUM_REQ strategy engines onto the single order_encode input.
- Sequences the encoder: issues exactly one in_valid pulse per order. No new order is issued until the encoder's 2-beat AXIS frame (header, then payload with tlast) has completed its handshake, snooped at the encoder output.
- Applies a token-bucket rate limit on egress orders. Sits between the strategy layer and order_encode → tx_bridge → MAC.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TOKENS_MAX, 8, bucket depth (max burst of orders).
- REFILL_PERIOD, 100, clk cycles per +1 token.
- WAIT_TIMEOUT, 64, max cycles in WAIT_TX before forced abort.
- MAX_QTY, 10000, qty ceiling used only by the optional risk check.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester order pending
- req_ready  out  NUM_REQ  one-hot accept pulse; handshake when req_valid&req_ready
- req_buy  in  NUM_REQ  side per requester (1=BUY)
- req_px  in  32*NUM_REQ  price; requester i at [32i+31:32i]
- req_qty  in  32*NUM_REQ  quantity, same packing
- enc_in_valid  out  1  to order_encode in_valid
- enc_in_buy  out  1  to order_encode in_buy
- enc_in_px  out  32  to order_encode in_px
- enc_in_qty  out  32  to order_encode in_qty
- snp_tvalid  in  1  encoder m_axis_tvalid (snoop)
- snp_tready  in  1  encoder m_axis_tready (snoop)
- snp_tlast  in  1  encoder m_axis_tlast (snoop)
- grant_id  out  3  index of the last accepted requester
- tokens  out  4  current bucket level
- tx_timeout  out  1  1-cycle pulse on WAIT_TX abort
- reject  out  1  1-cycle pulse on risk reject (0 without macro)

Behaviour:
- Reset values (async assert, sync release): state=IDLE, rr_ptr=0, tokens=TOKENS_MAX, refill_cnt=0, wait_cnt=0, all outputs 0.
- FSM IDLE:
  - Condition: any req_valid and tokens>0.
  - Action: pick the round-robin winner, searching from rr_ptr upward with wrap.
  - That cycle: req_ready[w]=1, latch buy/px/qty, grant_id=w, rr_ptr=w+1 mod NUM_REQ.
  - Transition: go ISSUE.
  - With tokens==0: no req_ready is asserted; requests wait.
- FSM ISSUE:
  - enc_in_valid=1 for exactly one cycle, driving the latched fields.
  - tokens decrements.
  - Transition: go WAIT_TX.
  - Latency: accept at cycle T → enc_in_valid at T+1.
- FSM WAIT_TX:
  - Exit: on snp_tvalid&snp_tready&snp_tlast, go IDLE. The next accept is possible in the following cycle.
  - wait_cnt counts cycles spent in WAIT_TX. On reaching WAIT_TIMEOUT: pulse tx_timeout, go IDLE.
- enc_in_px/qty/buy hold the latched values outside ISSUE. Only enc_in_valid is qualified.
- Token bucket:
  - refill_cnt wraps at REFILL_PERIOD-1; each wrap adds +1, saturating at TOKENS_MAX.
  - Refill and consume in the same cycle: net 0.
  - A refill at TOKENS_MAX is lost; refill_cnt keeps running.
- req_ready is never asserted outside IDLE. A requester dropping req_valid before grant is legal.
- Mid-frame backpressure (snp_tready=0) only extends WAIT_TX, subject to the timeout.
- Reset mid-frame: the in-flight order is abandoned and the bucket is refilled to full. The encoder shares rst.

Optional Feature:
- Macro: ORDER_SCHED_RISK_CHECK_EN.
- With macro:
  - In IDLE the winner is still handshaked (req_ready pulse).
  - If qty==0 or qty>MAX_QTY: reject pulses, no token is consumed, state stays IDLE, rr_ptr advances past the winner.
  - A rejected order never reaches the encoder.
- Without macro: reject tied 0, MAX_QTY unused, all accepted orders are issued.

Decomposition:
- Package order_pkg:
  - FSM state encoding (IDLE, ISSUE, WAIT_TX).
  - Side constants: SIDE_BUY=1, HDR_BUY=8'h42.
  - Price and qty width constant (32).
  - Order struct/typedef {buy, px, qty}.
- Sub-module rr_arbiter: NUM_REQ requests plus pointer in; one-hot grant and index out; combinational. Reused by the future cancel path.
- Token bucket stays inline (small counter pair).

Test Plan:
- Single order: req_valid[0]=1, buy=1, px=10050, qty=500, mac_tready=1 → req_ready[0] at T, enc_in_valid at T+1. MAC beat 1 [63:56]=8'h42; beat 2 tlast with [63:32]=10050; tokens 8→7.
- Fairness: req_valid=4'b1111 held for 8 grants → grant_id sequence 0,1,2,3,0,1,2,3. Never more than one order is in flight.
- Rate limit: TOKENS_MAX=8, REFILL_PERIOD=100, requests back-to-back → 8 orders issued, then no req_ready until the next refill. Thereafter exactly 1 order per 100 cycles.
- Backpressure/timeout: mac_tready=0 after the first beat → state holds WAIT_TX, tx_timeout pulses after 64 cycles, next request accepted the following cycle.
- Reset mid-frame: assert rst during WAIT_TX → outputs 0 immediately, tokens=8 after release, next order encodes correctly.
- Risk (macro on): qty=20000 → reject pulse, no enc_in_valid, tokens unchanged. Follow-up qty=500 from the next requester is issued normally.
